fft_frame_scheduler: RTL

Frame-level controller for the 32K FFT input path in the swept-source OCT pipeline. Each sweep trigger from the laser opens one FFT frame only when the FFT core can accept one. The block then gates ADC samples into exactly FFT_LEN beats and drives the sink handshake (master_sink_ena, master_sink_sop, inv_i) consumed by the input parser. It enforces an inter-frame gap, and it reports dropped sweeps and overruns.

---
 rtl/fft_sched_pkg.sv | 18 +
 rtl/fft_frame_scheduler_if.sv | 37 +++
 rtl/fft_sched_stats.sv | 27 ++
 rtl/fft_frame_scheduler.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared types and default sizing for the OCT FFT frame scheduler.
// Statistics counters are built only when FFT_SCHED_STATS_EN is defined.
package fft_sched_pkg;

    localparam int unsigned FFT_LEN_DEF = 32768;
    localparam int unsigned LEN_W_DEF   = 15;
    localparam int unsigned GAP_MIN_DEF = 4;
    localparam int unsigned GAP_W       = 8;
    localparam int unsigned FRAME_CNT_W = 32;
    localparam int unsigned DROP_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } sched_state_t;

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Sweep/ADC inputs and FFT sink handshake of the frame scheduler.
// master is the scheduler side, slave is the laser/ADC/FFT-core side.
interface fft_frame_scheduler_if #(
    parameter int unsigned LEN_W = fft_sched_pkg::LEN_W_DEF
);

    logic                                   enable;
    logic                                   inv_cfg;
    logic                                   sweep_trig;
    logic                                   sample_vld;
    logic                                   master_sink_dav;
    logic                                   ds_ready;
    logic                                   master_sink_ena;
    logic                                   master_sink_sop;
    logic                                   inv_i;
    logic                                   master_source_dav;
    logic [LEN_W-1:0]                       sample_idx;
    logic                                   busy;
    logic                                   frame_done;
    logic                                   drop_pulse;
    logic                                   overrun;
    logic [fft_sched_pkg::FRAME_CNT_W-1:0]  frame_cnt;
    logic [fft_sched_pkg::DROP_CNT_W-1:0]   drop_cnt;

    modport master (
        input  enable, inv_cfg, sweep_trig, sample_vld, master_sink_dav, ds_ready,
        output master_sink_ena, master_sink_sop, inv_i, master_source_dav,
               sample_idx, busy, frame_done, drop_pulse, overrun, frame_cnt, drop_cnt
    );

    modport slave (
        output enable, inv_cfg, sweep_trig, sample_vld, master_sink_dav, ds_ready,
        input  master_sink_ena, master_sink_sop, inv_i, master_source_dav,
               sample_idx, busy, frame_done, drop_pulse, overrun, frame_cnt, drop_cnt
    );

endinterface

// File: rtl/fft_sched_stats.sv
// Completed-frame (wrapping) and dropped-sweep (saturating) statistics counters.
module fft_sched_stats
    import fft_sched_pkg::*;
(
    input  logic                   clk_fft,
    input  logic                   reset_n,
    input  logic                   frame_inc,
    input  logic                   drop_inc,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    always_ff @(posedge clk_fft or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (frame_inc) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
            if (drop_inc && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Frame controller for the FFT input path: one sweep opens one FFT_LEN-beat frame.
// Optional statistics counters via FFT_SCHED_STATS_EN.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int unsigned FFT_LEN = FFT_LEN_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned GAP_MIN = GAP_MIN_DEF
) (
    input logic                   clk_fft,
    input logic                   reset_n,
    fft_frame_scheduler_if.master bus
);

    sched_state_t     state, state_nxt;
    logic [LEN_W-1:0] idx_q, idx_nxt;
    logic [LEN_W-1:0] sample_idx_q, sample_idx_nxt;
    logic [GAP_W-1:0] gap_q, gap_nxt;
    logic             frame_inv_q, frame_inv_nxt;
    logic             ena_q, ena_nxt;
    logic             sop_q, sop_nxt;
    logic             inv_q, inv_nxt;
    logic             src_dav_q, src_dav_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             drop_q, drop_nxt;
    logic             ovr_q, ovr_nxt;

    logic start_c;
    logic beat_c;
    logic last_c;
    logic gap_end_c;

    assign start_c   = (state == IDLE) && bus.sweep_trig && bus.enable && bus.master_sink_dav;
    assign beat_c    = (state == STREAM) && bus.sample_vld;
    assign last_c    = (idx_q == LEN_W'(FFT_LEN - 1));
    assign gap_end_c = (gap_q == GAP_W'(GAP_MIN - 1));

    // State register
    always_ff @(posedge clk_fft or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a frame, once opened, always runs to its last beat
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_c)           state_nxt = STREAM;
            STREAM:  if (beat_c && last_c)  state_nxt = GAP;
            GAP:     if (gap_end_c)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values; every output is registered below
    always_comb begin
        idx_nxt        = idx_q;
        sample_idx_nxt = sample_idx_q;
        gap_nxt        = '0;
        frame_inv_nxt  = frame_inv_q;
        ena_nxt        = beat_c;
        sop_nxt        = beat_c && (idx_q == '0);
        inv_nxt        = beat_c && frame_inv_q;
        src_dav_nxt    = bus.ds_ready;
        busy_nxt       = (state_nxt != IDLE);
        done_nxt       = beat_c && last_c;
        drop_nxt       = bus.sweep_trig && bus.enable &&
                         ((state != IDLE) || !bus.master_sink_dav);
        ovr_nxt        = ovr_q;

        if (start_c) begin
            idx_nxt       = '0;
            frame_inv_nxt = bus.inv_cfg;
        end
        if (beat_c) begin
            idx_nxt        = idx_q + LEN_W'(1);
            sample_idx_nxt = idx_q;
        end
        if (state == GAP) begin
            gap_nxt = gap_q + GAP_W'(1);
        end
        if (beat_c && !bus.master_sink_dav) begin
            ovr_nxt = 1'b1;
        end else if ((state == IDLE) && !bus.enable) begin
            ovr_nxt = 1'b0;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk_fft or negedge reset_n) begin
        if (!reset_n) begin
            idx_q        <= '0;
            sample_idx_q <= '0;
            gap_q        <= '0;
            frame_inv_q  <= 1'b0;
            ena_q        <= 1'b0;
            sop_q        <= 1'b0;
            inv_q        <= 1'b0;
            src_dav_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            idx_q        <= idx_nxt;
            sample_idx_q <= sample_idx_nxt;
            gap_q        <= gap_nxt;
            frame_inv_q  <= frame_inv_nxt;
            ena_q        <= ena_nxt;
            sop_q        <= sop_nxt;
            inv_q        <= inv_nxt;
            src_dav_q    <= src_dav_nxt;
            busy_q       <= busy_nxt;
            done_q       <= done_nxt;
            drop_q       <= drop_nxt;
            ovr_q        <= ovr_nxt;
        end
    end

    assign bus.master_sink_ena   = ena_q;
    assign bus.master_sink_sop   = sop_q;
    assign bus.inv_i             = inv_q;
    assign bus.master_source_dav = src_dav_q;
    assign bus.sample_idx        = sample_idx_q;
    assign bus.busy              = busy_q;
    assign bus.frame_done        = done_q;
    assign bus.drop_pulse        = drop_q;
    assign bus.overrun           = ovr_q;

`ifdef FFT_SCHED_STATS_EN
    // Counters step on the same edge that raises frame_done / drop_pulse
    fft_sched_stats u_stats (
        .clk_fft   (clk_fft),
        .reset_n   (reset_n),
        .frame_inc (done_nxt),
        .drop_inc  (drop_nxt),
        .frame_cnt (bus.frame_cnt),
        .drop_cnt  (bus.drop_cnt)
    );
`else
    assign bus.frame_cnt = '0;
    assign bus.drop_cnt  = '0;
`endif

endmodule
